// File: rtl/arkanoid_audio_pkg.sv
// Shared audio-path definitions: Q15 arithmetic widths, coefficient
// addresses, default low-pass coefficients and the IIR scheduler FSM states.
package arkanoid_audio_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 18;
  localparam int unsigned PROD_W    = DATA_W + COEF_W;
  localparam int unsigned ACC_W     = 36;
  localparam int unsigned Q15_SHIFT = 15;

  localparam logic [1:0] CFG_A2 = 2'd0;
  localparam logic [1:0] CFG_B1 = 2'd1;
  localparam logic [1:0] CFG_B2 = 2'd2;

  localparam int A2_DEFAULT = -18211;
  localparam int B1_DEFAULT = 7278;
  localparam int B2_DEFAULT = 7278;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B1,
    ST_B2,
    ST_A2,
    ST_WB,
    ST_DONE
  } iir_state_e;

  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_LOAD,
    ACC_ADD,
    ACC_SUB
  } acc_op_e;

  // Arithmetic shift (floor toward -inf) followed by clamp to 16-bit range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> Q15_SHIFT;
    if (sh > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (sh < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return sh[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/iir_mac_datapath.sv
// Shared multiply-accumulate datapath for the IIR scheduler: operand select,
// one signed 18x16 multiplier, 36-bit accumulator and shift+saturate output.
module iir_mac_datapath
  import arkanoid_audio_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  acc_op_e                  op_i,
  input  logic signed [COEF_W-1:0] b1_i,
  input  logic signed [COEF_W-1:0] b2_i,
  input  logic signed [COEF_W-1:0] a2_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] x1_i,
  input  logic signed [DATA_W-1:0] y1_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic signed [COEF_W-1:0] coef_sel;
  logic signed [DATA_W-1:0] data_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // Each accumulate step pairs one coefficient with one history tap.
  always_comb begin
    coef_sel = '0;
    data_sel = '0;
    unique case (op_i)
      ACC_LOAD: begin
        coef_sel = b1_i;
        data_sel = x_i;
      end
      ACC_ADD: begin
        coef_sel = b2_i;
        data_sel = x1_i;
      end
      ACC_SUB: begin
        coef_sel = a2_i;
        data_sel = y1_i;
      end
      default: begin
        coef_sel = '0;
        data_sel = '0;
      end
    endcase
  end

  assign prod = PROD_W'(coef_sel) * PROD_W'(data_sel);

  // Accumulator next-state: load, add or subtract the current product.
  always_comb begin
    acc_d = acc_q;
    unique case (op_i)
      ACC_LOAD: acc_d = ACC_W'(prod);
      ACC_ADD:  acc_d = acc_q + ACC_W'(prod);
      ACC_SUB:  acc_d = acc_q - ACC_W'(prod);
      default:  acc_d = acc_q;
    endcase
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign y_o = sat16(acc_q);

endmodule

// File: rtl/iir_lpf_scheduler.sv
// Time-multiplexed first-order IIR low-pass for NCH audio channels.
// Owns the sample-rate divider, the scheduling FSM, per-channel history and
// the pending/active coefficient registers; the arithmetic lives in
// iir_mac_datapath.
module iir_lpf_scheduler
  import arkanoid_audio_pkg::*;
#(
  parameter int unsigned NCH     = 3,
  parameter int unsigned DIV     = 256,
  parameter int          A2_INIT = A2_DEFAULT,
  parameter int          B1_INIT = B1_DEFAULT,
  parameter int          B2_INIT = B2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [16*NCH-1:0]     in,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [COEF_W-1:0]     cfg_data,
  output logic [16*NCH-1:0]     out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

  localparam logic signed [COEF_W-1:0] A2_RST = COEF_W'(A2_INIT);
  localparam logic signed [COEF_W-1:0] B1_RST = COEF_W'(B1_INIT);
  localparam logic signed [COEF_W-1:0] B2_RST = COEF_W'(B2_INIT);

  // A full NCH-channel sequence plus its strobe must fit in one period.
  if (DIV < 4 * NCH + 2) begin : g_div_check
    $error("iir_lpf_scheduler: DIV must be at least 4*NCH+2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe;

  iir_state_e       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  acc_op_e          acc_op;

  logic signed [DATA_W-1:0] x_q  [NCH];
  logic signed [DATA_W-1:0] x_d  [NCH];
  logic signed [DATA_W-1:0] x1_q [NCH];
  logic signed [DATA_W-1:0] x1_d [NCH];
  logic signed [DATA_W-1:0] y1_q [NCH];
  logic signed [DATA_W-1:0] y1_d [NCH];

  logic signed [COEF_W-1:0] a2_pend_q, a2_pend_d;
  logic signed [COEF_W-1:0] b1_pend_q, b1_pend_d;
  logic signed [COEF_W-1:0] b2_pend_q, b2_pend_d;
  logic signed [COEF_W-1:0] a2_act_q, a2_act_d;
  logic signed [COEF_W-1:0] b1_act_q, b1_act_d;
  logic signed [COEF_W-1:0] b2_act_q, b2_act_d;

  logic [16*NCH-1:0]        out_q, out_d;

  logic signed [DATA_W-1:0] x_cur;
  logic signed [DATA_W-1:0] x1_cur;
  logic signed [DATA_W-1:0] y1_cur;
  logic signed [DATA_W-1:0] y_new;

  // Sample-rate divider: counts while en is high, holds its value otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign strobe = en && (cnt_q == CNT_LAST);

  // Coefficient staging: writes land in the pending set, last write wins.
  always_comb begin
    a2_pend_d = a2_pend_q;
    b1_pend_d = b1_pend_q;
    b2_pend_d = b2_pend_q;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_A2:  a2_pend_d = cfg_data;
        CFG_B1:  b1_pend_d = cfg_data;
        CFG_B2:  b2_pend_d = cfg_data;
        default: ;
      endcase
    end
  end

  assign x_cur  = x_q[ch_q];
  assign x1_cur = x1_q[ch_q];
  assign y1_cur = y1_q[ch_q];

  // Scheduler next-state: capture on strobe, then B1/B2/A2/WB per channel.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    acc_op   = ACC_HOLD;
    x_d      = x_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    out_d    = out_q;
    a2_act_d = a2_act_q;
    b1_act_d = b1_act_q;
    b2_act_d = b2_act_q;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          for (int unsigned k = 0; k < NCH; k++) begin
            x_d[k] = in[16*k +: 16];
          end
          a2_act_d = a2_pend_q;
          b1_act_d = b1_pend_q;
          b2_act_d = b2_pend_q;
          ch_d     = '0;
          state_d  = ST_B1;
        end
      end
      ST_B1: begin
        acc_op  = ACC_LOAD;
        state_d = ST_B2;
      end
      ST_B2: begin
        acc_op  = ACC_ADD;
        state_d = ST_A2;
      end
      ST_A2: begin
        acc_op  = ACC_SUB;
        state_d = ST_WB;
      end
      ST_WB: begin
        y1_d[ch_q] = y_new;
        x1_d[ch_q] = x_cur;
        if (ch_q == CH_LAST) begin
          // out is loaded on the edge into DONE so it is already visible
          // in the same cycle that out_valid is asserted.
          for (int unsigned k = 0; k < NCH; k++) begin
            out_d[16*k +: 16] = y1_d[k];
          end
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_B1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All sequential state; reset returns to idle with cleared history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      x_q       <= '{default: '0};
      x1_q      <= '{default: '0};
      y1_q      <= '{default: '0};
      out_q     <= '0;
      a2_pend_q <= A2_RST;
      b1_pend_q <= B1_RST;
      b2_pend_q <= B2_RST;
      a2_act_q  <= A2_RST;
      b1_act_q  <= B1_RST;
      b2_act_q  <= B2_RST;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      ch_q      <= ch_d;
      x_q       <= x_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      out_q     <= out_d;
      a2_pend_q <= a2_pend_d;
      b1_pend_q <= b1_pend_d;
      b2_pend_q <= b2_pend_d;
      a2_act_q  <= a2_act_d;
      b1_act_q  <= b1_act_d;
      b2_act_q  <= b2_act_d;
    end
  end

  iir_mac_datapath u_mac (
    .clk   (clk),
    .rst_n (reset),
    .op_i  (acc_op),
    .b1_i  (b1_act_q),
    .b2_i  (b2_act_q),
    .a2_i  (a2_act_q),
    .x_i   (x_cur),
    .x1_i  (x1_cur),
    .y1_i  (y1_cur),
    .y_o   (y_new)
  );

  assign out       = out_q;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iir_lpf_scheduler.sv
// Directed bench for iir_lpf_scheduler (NCH=3, DIV=256, default coefficients).
module tb_iir_lpf_scheduler;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [47:0] in_bus;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic [47:0] out_bus;
  logic        out_valid;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  iir_lpf_scheduler #(.NCH(3), .DIV(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in_bus),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .out       (out_bus),
    .out_valid (out_valid),
    .busy      (busy)
  );

  function automatic int ch_out(input int k);
    logic signed [15:0] v;
    v = out_bus[16*k +: 16];
    return int'(v);
  endfunction

  task automatic set_inputs(input logic signed [15:0] c0, input logic signed [15:0] c1,
                            input logic signed [15:0] c2);
    in_bus = {c2, c1, c0};
  endtask

  // Holds reset for 3 cycles and releases it on a falling edge (cycle 0).
  task automatic apply_reset();
    reset    = 1'b0;
    en       = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic signed [17:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  task automatic wait_busy(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(16'sd10000, 16'sd10000, 16'sd10000);
    reset = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_bus !== 48'd0) begin
      tests_failed++; $display("FAIL reset_out: got %h want 0", out_bus);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle_after_release: busy %b valid %b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_dc_step();
    bit ok; int n; int v;
    set_inputs(16'sd10000, 16'sd10000, 16'sd10000);
    apply_reset();
    wait_valid(ok, n);
    for (int k = 0; k < NCH; k++) begin
      tests_run++;
      if (!ok || ch_out(k) != 2221) begin
        tests_failed++; $display("FAIL dc_first ch%0d: got %0d (valid seen %0d) want 2221", k, ch_out(k), ok);
      end
    end
    wait_valid(ok, n);
    for (int k = 0; k < NCH; k++) begin
      tests_run++;
      if (!ok || ch_out(k) != 5676) begin
        tests_failed++; $display("FAIL dc_second ch%0d: got %0d want 5676", k, ch_out(k));
      end
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (ch_out(0) != 5676) begin
      tests_failed++; $display("FAIL dc_hold: got %0d want 5676", ch_out(0));
    end
    for (int s = 3; s <= 20; s++) begin
      wait_valid(ok, n);
      tests_run++;
      if (!ok) begin
        tests_failed++; $display("FAIL dc_converge_timeout sample %0d: no out_valid want pulse", s);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      v = ch_out(k);
      tests_run++;
      if (v < 9998 || v > 10000) begin
        tests_failed++; $display("FAIL dc_converge ch%0d: got %0d want 9999+-1", k, v);
      end
    end
  endtask

  task automatic test_latency();
    int first_busy = -1; int busy_cnt = 0; int valid_cnt = 0;
    int v1 = -1; int v2 = -1;
    set_inputs(16'sd100, 16'sd200, 16'sd300);
    apply_reset();
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (out_valid === 1'b1) begin
        valid_cnt++;
        if (v1 < 0) v1 = i;
        else if (v2 < 0) v2 = i;
      end
    end
    tests_run++;
    if (first_busy != 256) begin
      tests_failed++; $display("FAIL lat_first_busy: got %0d want 256", first_busy);
    end
    tests_run++;
    if (v1 != 268) begin
      tests_failed++; $display("FAIL lat_first_valid: got %0d want 268", v1);
    end
    tests_run++;
    if (v2 != 524) begin
      tests_failed++; $display("FAIL lat_period: got %0d want 524", v2);
    end
    tests_run++;
    if (valid_cnt != 2) begin
      tests_failed++; $display("FAIL lat_valid_width: got %0d cycles want 2", valid_cnt);
    end
    tests_run++;
    if (busy_cnt != 26) begin
      tests_failed++; $display("FAIL lat_busy_cycles: got %0d want 26", busy_cnt);
    end
  endtask

  task automatic test_saturation();
    bit ok; int n;
    int exp_pos [3] = '{32766, 32767, 32767};
    int exp_neg [3] = '{-1, -32768, -32768};
    set_inputs(16'sd32767, 16'sd32767, 16'sd32767);
    apply_reset();
    cfg_write(2'd1, 18'sd32767);
    cfg_write(2'd2, 18'sd32767);
    cfg_write(2'd0, 18'sd0);
    for (int s = 0; s < 3; s++) begin
      wait_valid(ok, n);
      tests_run++;
      if (!ok || ch_out(0) != exp_pos[s] || ch_out(2) != exp_pos[s]) begin
        tests_failed++; $display("FAIL sat_pos sample %0d: got %0d/%0d want %0d", s, ch_out(0), ch_out(2), exp_pos[s]);
      end
    end
    set_inputs(-16'sd32768, -16'sd32768, -16'sd32768);
    for (int s = 0; s < 3; s++) begin
      wait_valid(ok, n);
      tests_run++;
      if (!ok || ch_out(1) != exp_neg[s]) begin
        tests_failed++; $display("FAIL sat_neg sample %0d: got %0d want %0d", s, ch_out(1), exp_neg[s]);
      end
    end
  endtask

  task automatic test_cfg_during_busy();
    bit ok; int n;
    int exp_v [3] = '{2221, 1234, 685};
    set_inputs(16'sd10000, 16'sd10000, 16'sd10000);
    apply_reset();
    wait_busy(ok, n);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL cfgbusy_start: no busy want busy within 600 cycles");
    end
    repeat (2) @(negedge clk);
    cfg_write(2'd1, 18'sd0);
    cfg_write(2'd2, 18'sd0);
    for (int s = 0; s < 3; s++) begin
      wait_valid(ok, n);
      tests_run++;
      if (!ok || ch_out(0) != exp_v[s] || ch_out(1) != exp_v[s]) begin
        tests_failed++; $display("FAIL cfgbusy sample %0d: got %0d/%0d want %0d", s, ch_out(0), ch_out(1), exp_v[s]);
      end
    end
  endtask

  task automatic test_cfg_strobe_edge();
    bit ok; int n;
    set_inputs(16'sd10000, 16'sd10000, 16'sd10000);
    apply_reset();
    repeat (255) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL strobe_cycle_idle: busy %b want 0", busy);
    end
    cfg_write(2'd1, 18'sd0);
    wait_valid(ok, n);
    tests_run++;
    if (!ok || ch_out(0) != 2221) begin
      tests_failed++; $display("FAIL cfgedge_first: got %0d want 2221", ch_out(0));
    end
    wait_valid(ok, n);
    tests_run++;
    if (!ok || ch_out(2) != 3455) begin
      tests_failed++; $display("FAIL cfgedge_second: got %0d want 3455", ch_out(2));
    end
  endtask

  task automatic test_channels();
    bit ok; int n;
    set_inputs(16'sd10000, -16'sd10000, 16'sd0);
    apply_reset();
    cfg_write(2'd3, 18'sd0);
    wait_valid(ok, n);
    tests_run++;
    if (!ok || ch_out(0) != 2221 || ch_out(1) != -2222 || ch_out(2) != 0) begin
      tests_failed++; $display("FAIL chan_first: got %0d %0d %0d want 2221 -2222 0", ch_out(0), ch_out(1), ch_out(2));
    end
    wait_valid(ok, n);
    tests_run++;
    if (!ok || ch_out(0) != 5676 || ch_out(1) != -5678 || ch_out(2) != 0) begin
      tests_failed++; $display("FAIL chan_second: got %0d %0d %0d want 5676 -5678 0", ch_out(0), ch_out(1), ch_out(2));
    end
  endtask

  task automatic test_mid_reset();
    bit ok; int n; int valid_seen = 0;
    set_inputs(16'sd10000, 16'sd10000, 16'sd10000);
    apply_reset();
    wait_valid(ok, n);
    wait_busy(ok, n);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || out_bus !== 48'd0) begin
      tests_failed++; $display("FAIL midreset_immediate: busy %b out %h want 0 0", busy, out_bus);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) valid_seen++;
    end
    tests_run++;
    if (valid_seen != 0) begin
      tests_failed++; $display("FAIL midreset_no_valid: got %0d pulses want 0", valid_seen);
    end
    reset = 1'b1;
    wait_valid(ok, n);
    tests_run++;
    if (!ok || n != 268 || ch_out(0) != 2221) begin
      tests_failed++; $display("FAIL midreset_history: got %0d at cycle %0d want 2221 at 268", ch_out(0), n);
    end
  endtask

  task automatic test_en_hold();
    bit ok; int n; int busy_seen = 0;
    set_inputs(16'sd10000, 16'sd10000, 16'sd10000);
    apply_reset();
    repeat (100) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy === 1'b1 || out_valid === 1'b1) busy_seen++;
    end
    tests_run++;
    if (busy_seen != 0) begin
      tests_failed++; $display("FAIL en_hold_activity: got %0d active cycles want 0", busy_seen);
    end
    en = 1'b1;
    wait_busy(ok, n);
    tests_run++;
    if (!ok || n != 156) begin
      tests_failed++; $display("FAIL en_resume: busy after %0d cycles want 156", n);
    end
    en = 1'b0;
    wait_valid(ok, n);
    tests_run++;
    if (!ok || n != 12 || ch_out(1) != 2221) begin
      tests_failed++; $display("FAIL en_fall_midseq: valid after %0d out %0d want 12 2221", n, ch_out(1));
    end
    en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dc_step();
    test_latency();
    test_saturation();
    test_cfg_during_busy();
    test_cfg_strobe_edge();
    test_channels();
    test_mid_reset();
    test_en_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
